snake_grid_builder: RTL and testbench
=====================================

# snake_grid_builder

Consumer side of the snake segment stream: it takes the per-segment x/y/exists sequence that the snake body sweep emits during a shift and rebuilds it as an H×V occupancy bitmap. Two banks are kept. One is filled from the stream while the other is presented to the VGA pixel path through a registered lookup port. At the end of each sweep the banks swap, so the display always shows a complete, stable snake frame.

## Interface
Parameters:
- H, 32: grid width in cells.
- V, 32: grid height in cells.

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: synchronous, active-high.
- seg_valid, input, 1: qualifies seg_x, seg_y and seg_exists this cycle.
- seg_x, input, logb2(H): segment column.
- seg_y, input, logb2(V): segment row.
- seg_exists, input, 1: segment is part of the live body.
- seg_last, input, 1: end of sweep, driven from end_shift. May arrive with or without seg_valid.
- ready, output, 1: write bank is cleared and accepting segments.
- frame_done, output, 1: one-cycle pulse on bank swap.
- frame_len, output, logb2(H*V)+1: live segment count of the frame now displayed.
- overrun, output, 1: sticky; seg_valid or seg_last arrived while ready=0.
- rd_x, input, logb2(H): display lookup column.
- rd_y, input, logb2(V): display lookup row.
- rd_occupied, output, 1: display-bank bit for the (rd_x, rd_y) presented one cycle earlier.
- overlap, output, 1: sticky per frame. Present only with SNAKE_GRID_OVERLAP_EN.

## Operation
- States: CLEAR, FILL, SWAP. Internal signals are a row counter (logb2(V) bits), disp_bank (1 bit) and a running live count.
- CLEAR:
  - Zeroes one H-bit row of the write bank per cycle, rows 0 to V-1.
  - After reset, CLEAR zeroes both banks.
  - Once row V-1 is cleared, go to FILL.
- FILL:
  - ready=1.
  - On seg_valid with seg_exists=1 and coordinates in range (seg_x<H, seg_y<V), set bit [seg_y][seg_x] in the write bank and increment the live count.
  - Segments with seg_exists=0 or out-of-range coordinates are ignored and not counted.
  - seg_last goes to SWAP. If seg_valid is high in the same cycle, that segment is written first.
- SWAP, one cycle:
  - Toggle disp_bank.
  - frame_len <= live count; then zero the live count.
  - Pulse frame_done.
  - Clear the per-frame overlap flag.
  - Go to CLEAR, which now clears the bank that was just hidden.
- seg_valid or seg_last outside FILL: the input is dropped and overrun is set. overrun clears only on reset.
- The live count saturates at H*V.
- Reset values:
  - ready=0, frame_done=0, frame_len=0, overrun=0, overlap=0, rd_occupied=0.
  - disp_bank=0, state CLEAR, row 0.
- Reset mid-FILL or mid-CLEAR: the partial frame is discarded and the full both-bank CLEAR restarts.

## Timing
- Reset released at cycle 0: CLEAR runs cycles 0 to V-1; ready=1 from cycle V.
- A segment accepted at cycle N is in the write bank at N+1. It is never visible on rd_occupied before the swap.
- seg_last at cycle N:
  - SWAP occupies cycle N+1, with frame_done=1 and ready=0.
  - A lookup presented at N+2 returns the new frame at N+3.
  - CLEAR runs N+2 to N+1+V; ready=1 from N+2+V.
- Lookup latency is exactly 1 cycle. rd_occupied uses the disp_bank value at the cycle the address is sampled.
- The upstream sweep period must exceed V+2 cycles. Anything shorter produces overrun, not corruption.

## Configuration
- SNAKE_GRID_OVERLAP_EN defined:
  - A counted segment whose target bit is already set raises overlap.
  - overlap is sticky until the next SWAP and is registered in the same cycle as the write.
  - This serves as a cross-check of the snake self-collision flag.
- Undefined: the overlap port and its logic are absent. Duplicate writes are silently idempotent and still counted.

## Structure
- Shared package snake_pkg holds:
  - the logb2 function;
  - default H and V;
  - the direction constants right=0, up=1, left=2, down=3;
  - the state encoding for CLEAR, FILL and SWAP.
- Sub-module snake_grid_bank, instantiated twice: V×H bit array with a row-clear port, a single-bit set port and a registered bit-read port. It also reports a "bit already set" value for the overlap check.

## Test plan
- Reset, then hold seg_valid=0 → ready rises at cycle 32 (V=32); rd_occupied=0 at every (x,y).
- Stream (16,16),(15,16),(14,16), all exists=1, with seg_last alongside the third segment → frame_done pulses once; frame_len=3; lookups at those cells return 1 and (17,16) returns 0.
- Second sweep with (16,17), exists=1, and (15,16), exists=0 → after the swap only (16,17) reads 1; frame_len=1; the old frame's bits are gone.
- Present seg_valid during CLEAR (the cycle after frame_done) → overrun=1 and stays 1 across later frames; the bit is not written.
- Assert reset mid-FILL after 5 segments → ready=0 for 32 cycles; all lookups return 0; frame_len=0.
- With SNAKE_GRID_OVERLAP_EN: stream (3,4) twice, then seg_last → overlap=1 until the next SWAP; frame_len=2.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid defaults, direction codes, builder state encoding and logb2
package snake_pkg;

  localparam int H_DEFAULT = 32;
  localparam int V_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_SWAP  = 2'd2
  } grid_state_t;

  // Bits needed to index n items (ceil log2).
  function automatic int logb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/snake_grid_builder_if.sv
// rtl/snake_grid_builder_if.sv - segment stream from the body sweep into the grid builder
interface snake_grid_builder_if
  import snake_pkg::*;
#(
  parameter int H = H_DEFAULT,
  parameter int V = V_DEFAULT
);
  localparam int XW = logb2(H);
  localparam int YW = logb2(V);

  logic          seg_valid;
  logic [XW-1:0] seg_x;
  logic [YW-1:0] seg_y;
  logic          seg_exists;
  logic          seg_last;
  logic          ready;

  modport master (
    output seg_valid, seg_x, seg_y, seg_exists, seg_last,
    input  ready
  );

  modport slave (
    input  seg_valid, seg_x, seg_y, seg_exists, seg_last,
    output ready
  );

endinterface

// File: rtl/snake_grid_bank.sv
// rtl/snake_grid_bank.sv - V x H occupancy bit array with row clear, bit set and registered bit read
module snake_grid_bank
  import snake_pkg::*;
#(
  parameter int H = H_DEFAULT,
  parameter int V = V_DEFAULT,
  localparam int XW = logb2(H),
  localparam int YW = logb2(V)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_en,
  input  logic [YW-1:0] clr_row,
  input  logic          set_en,
  input  logic [XW-1:0] set_x,
  input  logic [YW-1:0] set_y,
  output logic          set_hit,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_bit
);

  logic [H-1:0] mem [V];

  assign set_hit = mem[set_y][set_x];

  // Storage has no reset; the builder's CLEAR pass zeroes every row.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_row] <= '0;
    end else if (set_en) begin
      mem[set_y][set_x] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bit <= 1'b0;
    end else begin
      rd_bit <= mem[rd_y][rd_x];
    end
  end

endmodule

// File: rtl/snake_grid_builder.sv
// rtl/snake_grid_builder.sv - double-banked occupancy bitmap rebuilt from the segment stream; SNAKE_GRID_OVERLAP_EN adds overlap
module snake_grid_builder
  import snake_pkg::*;
#(
  parameter int H = H_DEFAULT,
  parameter int V = V_DEFAULT,
  localparam int XW = logb2(H),
  localparam int YW = logb2(V),
  localparam int LW = logb2(H * V) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  snake_grid_builder_if.slave  seg,
  output logic                 frame_done,
  output logic [LW-1:0]        frame_len,
  output logic                 overrun,
  input  logic [XW-1:0]        rd_x,
  input  logic [YW-1:0]        rd_y,
  output logic                 rd_occupied
`ifdef SNAKE_GRID_OVERLAP_EN
  ,
  output logic                 overlap
`endif
);

  localparam logic [YW-1:0] ROW_LAST = YW'(V - 1);
  localparam logic [LW-1:0] LIVE_MAX = LW'(H * V);

  grid_state_t   state;
  logic [YW-1:0] row;
  logic          disp_bank;
  logic          clear_both;
  logic          ready_q;
  logic          rd_sel;
  logic          rd_gate;
  logic [LW-1:0] live;
  logic          in_range;
  logic          accept;
  logic [1:0]    clr_en;
  logic [1:0]    set_en;
  logic [1:0]    set_hit;
  logic [1:0]    rd_bit;

  assign seg.ready = ready_q;
  assign in_range  = ({1'b0, seg.seg_x} < (XW+1)'(H)) && ({1'b0, seg.seg_y} < (YW+1)'(V));
  assign accept    = (state == ST_FILL) && seg.seg_valid && seg.seg_exists && in_range;

  // The write bank is always the one not on display.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign clr_en[b] = (state == ST_CLEAR) && (clear_both || (disp_bank != 1'(b)));
    assign set_en[b] = accept && (disp_bank != 1'(b));

    snake_grid_bank #(.H(H), .V(V)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .clr_en  (clr_en[b]),
      .clr_row (row),
      .set_en  (set_en[b]),
      .set_x   (seg.seg_x),
      .set_y   (seg.seg_y),
      .set_hit (set_hit[b]),
      .rd_x    (rd_x),
      .rd_y    (rd_y),
      .rd_bit  (rd_bit[b])
    );
  end

  // Lookups during the post-reset clear read zero rather than half-cleared rows.
  assign rd_occupied = rd_gate & rd_bit[rd_sel];

`ifndef SNAKE_GRID_OVERLAP_EN
  logic unused_hit;
  assign unused_hit = ^set_hit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      row        <= '0;
      disp_bank  <= 1'b0;
      clear_both <= 1'b1;
      ready_q    <= 1'b0;
      live       <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      overrun    <= 1'b0;
      rd_sel     <= 1'b0;
      rd_gate    <= 1'b0;
`ifdef SNAKE_GRID_OVERLAP_EN
      overlap    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      rd_sel     <= disp_bank;
      rd_gate    <= !clear_both;
      if ((seg.seg_valid || seg.seg_last) && !ready_q) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_CLEAR: begin
          if (row == ROW_LAST) begin
            row        <= '0;
            clear_both <= 1'b0;
            ready_q    <= 1'b1;
            state      <= ST_FILL;
          end else begin
            row <= row + YW'(1);
          end
        end
        ST_FILL: begin
          if (accept && (live != LIVE_MAX)) begin
            live <= live + LW'(1);
          end
`ifdef SNAKE_GRID_OVERLAP_EN
          if (accept && set_hit[~disp_bank]) begin
            overlap <= 1'b1;
          end
`endif
          if (seg.seg_last) begin
            ready_q    <= 1'b0;
            frame_done <= 1'b1;
            state      <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          disp_bank <= ~disp_bank;
          frame_len <= live;
          live      <= '0;
`ifdef SNAKE_GRID_OVERLAP_EN
          overlap   <= 1'b0;
`endif
          state     <= ST_CLEAR;
        end
        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_grid_builder.sv
// tb/tb_snake_grid_builder.sv - table, sequence and random checks of snake_grid_builder against a frame model
`timescale 1ns/1ps
module tb_snake_grid_builder;

  localparam int H  = 32;
  localparam int V  = 32;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam int LW = $clog2(H * V) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_done;
  logic [LW-1:0] frame_len;
  logic          overrun;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_occupied;
`ifdef SNAKE_GRID_OVERLAP_EN
  logic          overlap;
`endif

  int total = 0;
  int bad   = 0;

  bit [H-1:0] disp_m [V];
  bit [H-1:0] wr_m   [V];
  int  live_m;
  int  len_m;
  bit  overrun_m;
  bit  ovl_m;

  typedef struct { bit valid; int x; int y; bit ex; bit last; int exp_len; } vec_t;
  typedef struct { int frame; int x; int y; bit occ; } look_t;
  vec_t  vecs  [8];
  look_t looks [10];

  snake_grid_builder_if #(.H(H), .V(V)) sg ();

  snake_grid_builder #(.H(H), .V(V)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (sg),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .overrun     (overrun),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_occupied (rd_occupied)
`ifdef SNAKE_GRID_OVERLAP_EN
    ,
    .overlap     (overlap)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ovl(input string name);
`ifdef SNAKE_GRID_OVERLAP_EN
    chk(name, int'(overlap), int'(ovl_m));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sg.seg_valid  = 1'b0;
    sg.seg_x      = '0;
    sg.seg_y      = '0;
    sg.seg_exists = 1'b0;
    sg.seg_last   = 1'b0;
  endtask

  task automatic model_reset();
    for (int y = 0; y < V; y++) begin
      disp_m[y] = '0;
      wr_m[y]   = '0;
    end
    live_m    = 0;
    len_m     = 0;
    overrun_m = 1'b0;
    ovl_m     = 1'b0;
  endtask

  // One stream beat while the builder is filling; on seg_last also steps through the swap.
  task automatic send(input bit valid, input int x, input int y, input bit ex, input bit last);
    sg.seg_valid  = valid;
    sg.seg_x      = XW'(x);
    sg.seg_y      = YW'(y);
    sg.seg_exists = ex;
    sg.seg_last   = last;
    tick();
    idle();
    if (valid && ex) begin
      if (wr_m[y][x]) ovl_m = 1'b1;
      wr_m[y][x] = 1'b1;
      if (live_m < H * V) live_m++;
    end
    chk("overrun_track", int'(overrun), int'(overrun_m));
    chk_ovl("overlap_fill");
    if (last) begin
      chk("swap_frame_done", int'(frame_done), 1);
      chk("swap_ready_low", int'(sg.ready), 0);
      tick();
      disp_m = wr_m;
      for (int r = 0; r < V; r++) wr_m[r] = '0;
      len_m  = live_m;
      live_m = 0;
      ovl_m  = 1'b0;
      chk("frame_done_single", int'(frame_done), 0);
      chk("frame_len", int'(frame_len), len_m);
      chk("clear_ready_low", int'(sg.ready), 0);
      chk_ovl("overlap_cleared");
    end else begin
      chk("fill_ready", int'(sg.ready), 1);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!sg.ready && n < 4 * V) begin
      tick();
      n++;
    end
    if (!sg.ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic lookup_chk(input string name, input int x, input int y, input bit exp);
    rd_x = XW'(x);
    rd_y = YW'(y);
    tick();
    chk(name, int'(rd_occupied), int'(exp));
  endtask

  task automatic scan_all(input string name);
    int errs;
    errs = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        rd_x = XW'(x);
        rd_y = YW'(y);
        tick();
        if (rd_occupied != disp_m[y][x]) errs++;
      end
    end
    chk(name, errs, 0);
  endtask

  initial begin
    int f;
    int n;
    int p;

    idle();
    reset = 1'b1;
    rd_x  = '0;
    rd_y  = '0;
    model_reset();

    vecs[0] = '{1'b1, 16, 16, 1'b1, 1'b0, -1};
    vecs[1] = '{1'b1, 15, 16, 1'b1, 1'b0, -1};
    vecs[2] = '{1'b1, 14, 16, 1'b1, 1'b1,  3};
    vecs[3] = '{1'b1, 16, 17, 1'b1, 1'b0, -1};
    vecs[4] = '{1'b1, 15, 16, 1'b0, 1'b1,  1};
    vecs[5] = '{1'b1,  3,  4, 1'b1, 1'b0, -1};
    vecs[6] = '{1'b1,  3,  4, 1'b1, 1'b0, -1};
    vecs[7] = '{1'b0,  0,  0, 1'b0, 1'b1,  2};

    looks[0] = '{0, 16, 16, 1'b1};
    looks[1] = '{0, 15, 16, 1'b1};
    looks[2] = '{0, 14, 16, 1'b1};
    looks[3] = '{0, 17, 16, 1'b0};
    looks[4] = '{1, 16, 17, 1'b1};
    looks[5] = '{1, 16, 16, 1'b0};
    looks[6] = '{1, 15, 16, 1'b0};
    looks[7] = '{1,  5,  5, 1'b0};
    looks[8] = '{2,  3,  4, 1'b1};
    looks[9] = '{2, 16, 17, 1'b0};

    repeat (3) tick();
    chk("rst_ready", int'(sg.ready), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_len", int'(frame_len), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rd_occupied", int'(rd_occupied), 0);
    chk_ovl("rst_overlap");

    reset = 1'b0;
    for (int k = 0; k < V; k++) begin
      chk("init_ready_low", int'(sg.ready), 0);
      tick();
    end
    chk("init_ready_high", int'(sg.ready), 1);
    scan_all("init_scan_zero");

    f = 0;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].valid, vecs[i].x, vecs[i].y, vecs[i].ex, vecs[i].last);
      if (vecs[i].last) begin
        chk("tbl_frame_len", int'(frame_len), vecs[i].exp_len);
        p = 0;
        if (f == 1) begin
          sg.seg_valid  = 1'b1;
          sg.seg_exists = 1'b1;
          sg.seg_x      = XW'(5);
          sg.seg_y      = YW'(5);
          tick();
          idle();
          overrun_m = 1'b1;
          chk("overrun_in_clear", int'(overrun), 1);
          p = 1;
        end
        wait_ready(n);
        chk("tbl_clear_cycles", n, V - p);
        for (int j = 0; j < 10; j++) begin
          if (looks[j].frame == f) lookup_chk("tbl_lookup", looks[j].x, looks[j].y, looks[j].occ);
        end
        scan_all("tbl_scan");
        f++;
      end
    end
    chk("overrun_sticky", int'(overrun), 1);

    for (int s = 0; s < 6; s++) begin
      int nseg;
      int px;
      int py;
      nseg = $urandom_range(1, 24);
      px = 0;
      py = 0;
      for (int i = 0; i < nseg; i++) begin
        int x;
        int y;
        bit ex;
        bit fin;
        bit merge;
        repeat ($urandom_range(0, 2)) tick();
        if (i > 0 && $urandom_range(0, 4) == 0) begin
          x = px;
          y = py;
        end else begin
          x = $urandom_range(0, H - 1);
          y = $urandom_range(0, V - 1);
        end
        ex    = ($urandom_range(0, 4) != 0);
        fin   = (i == nseg - 1);
        merge = 1'($urandom_range(0, 1));
        send(1'b1, x, y, ex, fin && merge);
        if (fin && !merge) send(1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1'b1, 1'b1);
        if (!fin && $urandom_range(0, 2) == 0) lookup_chk("hidden_until_swap", x, y, disp_m[y][x]);
        px = x;
        py = y;
      end
      wait_ready(n);
      chk("rand_clear_cycles", n, V);
      scan_all("rand_scan");
    end

    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        send(1'b1, x, y, 1'b1, 1'b0);
      end
    end
    repeat (6) send(1'b1, 2, 3, 1'b1, 1'b0);
    send(1'b1, 1, 1, 1'b1, 1'b1);
    chk("sat_frame_len", int'(frame_len), H * V);
    wait_ready(n);
    chk("sat_clear_cycles", n, V);
    scan_all("sat_scan_full");

    for (int i = 0; i < 5; i++) send(1'b1, i, 2 * i, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("midfill_rst_ready", int'(sg.ready), 0);
    chk("midfill_rst_len", int'(frame_len), 0);
    chk("midfill_rst_overrun", int'(overrun), 0);
    chk("midfill_rst_done", int'(frame_done), 0);
    chk_ovl("midfill_rst_overlap");
    for (int k = 0; k < V; k++) begin
      chk("midfill_clear_ready_low", int'(sg.ready), 0);
      lookup_chk("midfill_clear_lookup", k, V - 1 - k, 1'b0);
    end
    chk("midfill_ready_high", int'(sg.ready), 1);
    scan_all("midfill_scan_zero");

    send(1'b1, 7, 7, 1'b1, 1'b1);
    chk("post_rst_len", int'(frame_len), 1);
    wait_ready(n);
    chk("post_rst_clear_cycles", n, V);
    lookup_chk("post_rst_lookup", 7, 7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
